// File: rtl/reg_to_obi_bridge.sv
// rtl/reg_to_obi_bridge.sv - reg-bus responder issuing one OBI initiator transaction per request (optional timeout: REG_TO_OBI_TIMEOUT_EN)
module reg_to_obi_bridge #(
    parameter logic [31:0] BASE_OFFSET    = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // reg-bus request
    input  logic [31:0] reg_req_addr_i,
    input  logic        reg_req_write_i,
    input  logic [31:0] reg_req_wdata_i,
    input  logic [3:0]  reg_req_wstrb_i,
    input  logic        reg_req_valid_i,
    // reg-bus response
    output logic [31:0] reg_rsp_rdata_o,
    output logic        reg_rsp_error_o,
    output logic        reg_rsp_ready_o,
    // OBI request
    output logic        obi_req_req_o,
    output logic        obi_req_we_o,
    output logic [3:0]  obi_req_be_o,
    output logic [31:0] obi_req_addr_o,
    output logic [31:0] obi_req_wdata_o,
    // OBI response
    input  logic        obi_resp_gnt_i,
    input  logic        obi_resp_rvalid_i,
    input  logic [31:0] obi_resp_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Timeout window must fit the 16-bit counter and allow at least one wait cycle.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("reg_to_obi_bridge: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t      state_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        req_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    // Next-state values for the capture and response-data registers.
    logic [31:0] addr_d;
    logic [31:0] rdata_d;
    logic        rsp_take;

    assign addr_d  = reg_req_addr_i + BASE_OFFSET;
    assign rdata_d = we_q ? 32'h0 : obi_resp_rdata_i;

`ifdef REG_TO_OBI_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic        orphan_q;
    logic        error_q;

    // An rvalid belonging to an abandoned transaction must not complete the current one.
    assign rsp_take        = obi_resp_rvalid_i && !orphan_q;
    assign reg_rsp_error_o = error_q;
`else
    assign rsp_take        = obi_resp_rvalid_i;
    assign reg_rsp_error_o = 1'b0;
`endif

    assign obi_req_req_o   = req_q;
    assign obi_req_we_o    = we_q;
    assign obi_req_be_o    = be_q;
    assign obi_req_addr_o  = addr_q;
    assign obi_req_wdata_o = wdata_q;
    assign reg_rsp_ready_o = ready_q;
    assign reg_rsp_rdata_o = rdata_q;
    assign busy_o          = (state_q != IDLE);

    // Bridge FSM: capture the reg request, run one OBI request/response, pulse ready for one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            req_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
`ifdef REG_TO_OBI_TIMEOUT_EN
            cnt_q    <= 16'h0;
            orphan_q <= 1'b0;
            error_q  <= 1'b0;
`endif
        end else begin
`ifdef REG_TO_OBI_TIMEOUT_EN
            // The first rvalid after an abandoned response is the stale one; drop it in any state.
            if (obi_resp_rvalid_i && orphan_q) begin
                orphan_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (reg_req_valid_i) begin
                        addr_q  <= addr_d;
                        we_q    <= reg_req_write_i;
                        be_q    <= reg_req_wstrb_i;
                        wdata_q <= reg_req_wdata_i;
                        req_q   <= 1'b1;
                        state_q <= REQ;
`ifdef REG_TO_OBI_TIMEOUT_EN
                        cnt_q   <= 16'h0;
`endif
                    end
                end
                REQ: begin
                    if (obi_resp_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= RESP;
`ifdef REG_TO_OBI_TIMEOUT_EN
                        cnt_q   <= 16'h0;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        rdata_q <= 32'hBADCAB1E;
                        error_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rdata_q <= rdata_d;
                        ready_q <= 1'b1;
                        state_q <= DONE;
`ifdef REG_TO_OBI_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q  <= 32'hBADCAB1E;
                        ready_q  <= 1'b1;
                        error_q  <= 1'b1;
                        orphan_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q    <= cnt_q + 16'd1;
`endif
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    rdata_q <= 32'h0;
`ifdef REG_TO_OBI_TIMEOUT_EN
                    error_q <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// tb/tb_reg_to_obi_bridge.sv - directed self-checking bench for reg_to_obi_bridge
module tb_reg_to_obi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_ready;
    logic        obi_req;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_addr;
    logic [31:0] obi_wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] obi_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration and log
    int          gnt_wait    = 0;
    int          rv_wait     = 0;
    logic        rv_block    = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          n_obi       = 0;
    int          req_cycles  = 0;
    logic        stable      = 1'b1;
    logic [31:0] last_addr   = 32'h0;
    logic        last_we     = 1'b0;
    logic [3:0]  last_be     = 4'h0;
    logic [31:0] last_wdata  = 32'h0;

    always #5 clk = ~clk;

    reg_to_obi_bridge #(
        .BASE_OFFSET   (32'h2000_0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .reg_req_addr_i   (req_addr),
        .reg_req_write_i  (req_write),
        .reg_req_wdata_i  (req_wdata),
        .reg_req_wstrb_i  (req_wstrb),
        .reg_req_valid_i  (req_valid),
        .reg_rsp_rdata_o  (rsp_rdata),
        .reg_rsp_error_o  (rsp_error),
        .reg_rsp_ready_o  (rsp_ready),
        .obi_req_req_o    (obi_req),
        .obi_req_we_o     (obi_we),
        .obi_req_be_o     (obi_be),
        .obi_req_addr_o   (obi_addr),
        .obi_req_wdata_o  (obi_wdata),
        .obi_resp_gnt_i   (gnt),
        .obi_resp_rvalid_i(rvalid),
        .obi_resp_rdata_i (obi_rdata),
        .busy_o           (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // OBI slave model: configurable grant and response wait-states, one outstanding response
    initial begin
        logic        in_req;
        logic        pend;
        int          g_cnt;
        int          rv_cnt;
        logic [31:0] pend_rdata;
        logic [31:0] f_addr;
        logic [31:0] f_wdata;
        logic [3:0]  f_be;
        logic        f_we;
        in_req = 1'b0; pend = 1'b0; g_cnt = 0; rv_cnt = 0; pend_rdata = 32'h0;
        f_addr = 32'h0; f_wdata = 32'h0; f_be = 4'h0; f_we = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; obi_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            gnt = 1'b0; rvalid = 1'b0; obi_rdata = 32'h0;
            if (!rst_n) begin
                in_req = 1'b0;
                pend   = 1'b0;
            end else begin
                if (pend && !rv_block) begin
                    if (rv_cnt == 0) begin
                        rvalid    = 1'b1;
                        obi_rdata = pend_rdata;
                        pend      = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (obi_req) begin
                    if (!in_req) begin
                        in_req = 1'b1; g_cnt = gnt_wait; req_cycles = 0; stable = 1'b1;
                        f_addr = obi_addr; f_wdata = obi_wdata; f_be = obi_be; f_we = obi_we;
                    end
                    req_cycles++;
                    if (obi_addr !== f_addr || obi_wdata !== f_wdata || obi_be !== f_be || obi_we !== f_we)
                        stable = 1'b0;
                    if (g_cnt == 0) begin
                        gnt = 1'b1; in_req = 1'b0; pend = 1'b1; rv_cnt = rv_wait;
                        pend_rdata = slave_rdata; n_obi++;
                        last_addr = obi_addr; last_we = obi_we; last_be = obi_be; last_wdata = obi_wdata;
                    end else begin
                        g_cnt--;
                    end
                end else begin
                    in_req = 1'b0;
                end
            end
        end
    end

    // One reg-bus transaction; returns one cycle after ready so a following call is back-to-back.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er, output int lat);
        logic done;
        req_addr = a; req_write = w; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
        lat = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
        while (!done) begin
            tick();
            lat++;
            if (rsp_ready) begin
                rd = rsp_rdata; er = rsp_error; done = 1'b1;
            end else if (lat >= 100) begin
                check_eq("ready_within_bound", 32'(rsp_ready), 32'h1);
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          obi_before;

        rst_n = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0; req_wstrb = 4'h0; req_valid = 1'b0;
        tick(); tick();
        check_eq("rst_req",   32'(obi_req),   32'h0);
        check_eq("rst_ready", 32'(rsp_ready), 32'h0);
        check_eq("rst_busy",  32'(busy),      32'h0);
        check_eq("rst_rdata", rsp_rdata,      32'h0);
        check_eq("rst_error", 32'(rsp_error), 32'h0);
        check_eq("rst_addr",  obi_addr,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // read, zero-wait slave
        slave_rdata = 32'hCAFE_F00D;
        do_txn(32'h100, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check_eq("rd_latency", 32'(lat), 32'd3);
        check_eq("rd_rdata",   rd,       32'hCAFE_F00D);
        check_eq("rd_error",   32'(er),  32'h0);
        check_eq("rd_addr",    last_addr, 32'h2000_0100);
        check_eq("rd_we",      32'(last_we), 32'h0);
        check_eq("idle_rdata_zero", rsp_rdata, 32'h0);

        // write, grant delayed 4 cycles
        gnt_wait = 4;
        slave_rdata = 32'h9999_9999;
        do_txn(32'h40, 1'b1, 32'h1234_5678, 4'b0011, rd, er, lat);
        gnt_wait = 0;
        check_eq("wr_latency",    32'(lat), 32'd7);
        check_eq("wr_req_cycles", 32'(req_cycles), 32'd5);
        check_eq("wr_stable",     32'(stable), 32'h1);
        check_eq("wr_be",         32'(last_be), 32'h3);
        check_eq("wr_wdata",      last_wdata, 32'h1234_5678);
        check_eq("wr_we",         32'(last_we), 32'h1);
        check_eq("wr_addr",       last_addr, 32'h2000_0040);
        check_eq("wr_rdata",      rd, 32'h0);

        // back-to-back read then write with wstrb=0
        obi_before = n_obi;
        slave_rdata = 32'h1111_2222;
        do_txn(32'h200, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check_eq("b2b1_latency", 32'(lat), 32'd3);
        check_eq("b2b1_rdata",   rd, 32'h1111_2222);
        do_txn(32'h204, 1'b1, 32'hA5A5_A5A5, 4'h0, rd, er, lat);
        check_eq("b2b2_latency", 32'(lat), 32'd3);
        check_eq("b2b2_rdata",   rd, 32'h0);
        check_eq("b2b2_be",      32'(last_be), 32'h0);
        check_eq("b2b2_addr",    last_addr, 32'h2000_0204);
        check_eq("b2b_obi_count", 32'(n_obi - obi_before), 32'd2);

        // address wrap with two rvalid wait-states
        rv_wait = 2;
        slave_rdata = 32'h5555_AAAA;
        do_txn(32'hF000_0000, 1'b0, 32'h0, 4'hF, rd, er, lat);
        rv_wait = 0;
        check_eq("wrap_addr",    last_addr, 32'h1000_0000);
        check_eq("wrap_latency", 32'(lat), 32'd5);
        check_eq("wrap_rdata",   rd, 32'h5555_AAAA);

        // reset while waiting in RESP
        rv_block = 1'b1;
        slave_rdata = 32'hDEAD_0000;
        req_addr = 32'h300; req_write = 1'b0; req_wdata = 32'h0; req_wstrb = 4'hF; req_valid = 1'b1;
        tick(); tick();
        check_eq("mid_busy",    32'(busy), 32'h1);
        check_eq("mid_req_low", 32'(obi_req), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(obi_req), 32'h0);
        check_eq("arst_ready", 32'(rsp_ready), 32'h0);
        check_eq("arst_busy",  32'(busy), 32'h0);
        check_eq("arst_addr",  obi_addr, 32'h0);
        req_valid = 1'b0;
        rv_block = 1'b0;
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        slave_rdata = 32'h7777_8888;
        do_txn(32'h8, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check_eq("post_rst_latency", 32'(lat), 32'd3);
        check_eq("post_rst_rdata",   rd, 32'h7777_8888);
        check_eq("post_rst_addr",    last_addr, 32'h2000_0008);

`ifdef REG_TO_OBI_TIMEOUT_EN
        // response timeout, stale rvalid discarded, next read correct
        rv_block = 1'b1;
        slave_rdata = 32'hDEAD_DEAD;
        do_txn(32'h10, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check_eq("to_latency", 32'(lat), 32'd10);
        check_eq("to_error",   32'(er), 32'h1);
        check_eq("to_rdata",   rd, 32'hBADC_AB1E);
        slave_rdata = 32'h600D_F00D;
        rv_block = 1'b0;
        do_txn(32'h14, 1'b0, 32'h0, 4'hF, rd, er, lat);
        check_eq("after_to_latency", 32'(lat), 32'd3);
        check_eq("after_to_rdata",   rd, 32'h600D_F00D);
        check_eq("after_to_error",   32'(er), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
